// File: rtl/hb_mac_arbiter_pkg.sv
// Shared types for the halfband MAC arbiter: widths, requester ids,
// FSM states, the beat bundle and the round-robin pick helper.
package karaoke_pkg;
   localparam int N_REQ = 3;
   localparam int DW = 16;
   localparam int CW = 18;
   localparam int AW = 40;
   localparam int MAX_BEATS = 32;
   localparam int PW = DW + CW;
   localparam int BCW = $clog2(MAX_BEATS + 1);

   typedef logic [1:0] req_id_t;
   typedef logic [BCW-1:0] beat_cnt_t;

   typedef enum logic {
      IDLE,
      BURST
   } arb_state_t;

   typedef struct packed {
      logic [DW-1:0] x;
      logic [CW-1:0] c;
      logic first;
      logic last;
      req_id_t id;
      logic vld;
   } mac_beat_t;

   // First requester above ptr, wrapping; lower distance wins.
   function automatic req_id_t rr_pick(
      req_id_t ptr,
      logic [N_REQ-1:0] req
   );
      req_id_t win;
      int idx;
      win = ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (req[idx]) win = req_id_t'(idx);
      end
      return win;
   endfunction
endpackage

// File: rtl/hb_mac_arbiter_if.sv
// Requester-side bus of the shared halfband MAC: beats in,
// grants and accumulated responses out.
interface hb_mac_arbiter_if;
   import karaoke_pkg::*;

   logic [N_REQ-1:0] req;
   logic [DW-1:0] req_x [N_REQ];
   logic [CW-1:0] req_c [N_REQ];
   logic [N_REQ-1:0] req_last;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] rsp_valid;
   logic [AW-1:0] rsp_acc;
   logic err_overrun;

   modport master (
      output req, req_x, req_c, req_last,
      input gnt, rsp_valid, rsp_acc, err_overrun
   );

   modport slave (
      input req, req_x, req_c, req_last,
      output gnt, rsp_valid, rsp_acc, err_overrun
   );
endinterface

// File: rtl/hb_mac_arbiter_mac_pipe.sv
// Two-stage signed multiply-accumulate; the first flag restarts the
// sum so bursts can run back to back without a bubble.
module mac_pipe
   import karaoke_pkg::*;
(
   input logic clk,
   input logic reset_n,
   input mac_beat_t beat_i,
   output logic [N_REQ-1:0] rsp_valid_o,
   output logic [AW-1:0] rsp_acc_o
);
   logic [PW-1:0] xs, cs;
   logic [PW-1:0] prod_q, prod_d;
   logic first_q, last_q, vld_q;
   req_id_t id_q;
   logic [AW-1:0] prod_x, acc_q, acc_d;
   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [AW-1:0] rsp_acc_q;

   // Low PW bits of a sign-extended product equal the signed product.
   always_comb begin
      xs = {{(PW-DW){beat_i.x[DW-1]}}, beat_i.x};
      cs = {{(PW-CW){beat_i.c[CW-1]}}, beat_i.c};
      prod_d = xs * cs;
      prod_x = {{(AW-PW){prod_q[PW-1]}}, prod_q};
      acc_d = first_q ? prod_x : acc_q + prod_x;
      rsp_valid_d = '0;
      if (vld_q && last_q) rsp_valid_d[id_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prod_q <= '0;
         first_q <= 1'b0;
         last_q <= 1'b0;
         id_q <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= beat_i.vld;
         if (beat_i.vld) begin
            prod_q <= prod_d;
            first_q <= beat_i.first;
            last_q <= beat_i.last;
            id_q <= beat_i.id;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         rsp_valid_q <= '0;
         rsp_acc_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         if (vld_q) acc_q <= acc_d;
         if (vld_q && last_q) rsp_acc_q <= acc_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_acc_o = rsp_acc_q;
endmodule

// File: rtl/hb_mac_arbiter.sv
// Burst-granular round-robin arbiter sharing one MAC between the
// three halfband decimators.
module hb_mac_arbiter
   import karaoke_pkg::*;
(
   input logic clk,
   input logic reset_n,
   hb_mac_arbiter_if.slave bus
);
   arb_state_t state_q, state_d;
   req_id_t owner_q, owner_d;
   req_id_t rr_q, rr_d;
   beat_cnt_t cnt_q, cnt_d, cnt_nx;
   logic err_q, err_d;
   req_id_t src;
   logic take, ovr, done;
   logic [N_REQ-1:0] gnt;
   mac_beat_t beat;

   // Beat source: round-robin winner when idle, locked owner in a burst.
   always_comb begin
      src = (state_q == IDLE) ? rr_pick(rr_q, bus.req) : owner_q;
      take = (state_q == IDLE) ? |bus.req : bus.req[src];
      cnt_nx = cnt_q + beat_cnt_t'(1);
      ovr = (state_q == BURST) && (cnt_nx == beat_cnt_t'(MAX_BEATS));
      done = bus.req_last[src] | ovr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q <= rr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d = rr_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (take) begin
         unique case (state_q)
            IDLE: begin
               if (done) begin
                  rr_d = src;
               end else begin
                  state_d = BURST;
                  owner_d = src;
                  cnt_d = beat_cnt_t'(1);
               end
            end
            BURST: begin
               if (done) begin
                  state_d = IDLE;
                  rr_d = src;
                  cnt_d = '0;
                  err_d = err_q | ovr;
               end else begin
                  cnt_d = cnt_nx;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      gnt = '0;
      beat = '0;
      if (take && reset_n) begin
         gnt[src] = 1'b1;
         beat.vld = 1'b1;
      end
      beat.x = bus.req_x[src];
      beat.c = bus.req_c[src];
      beat.first = (state_q == IDLE);
      beat.last = done;
      beat.id = src;
   end

   mac_pipe u_mac (
      .clk(clk),
      .reset_n(reset_n),
      .beat_i(beat),
      .rsp_valid_o(bus.rsp_valid),
      .rsp_acc_o(bus.rsp_acc)
   );

   assign bus.gnt = gnt;
   assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_hb_mac_arbiter.sv
// Bench for hb_mac_arbiter: queued requesters, burst-level arbitration
// model and a response scoreboard.
module tb_hb_mac_arbiter;
   import karaoke_pkg::*;

   typedef struct {
      int x;
      int c;
      bit last;
      int gap;
   } beat_t;

   typedef struct {
      int id;
      logic [AW-1:0] acc;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   exp_t exp_q[$];
   int seen[$];

   hb_mac_arbiter_if ifc();

   hb_mac_arbiter dut (
      .clk(clk),
      .reset_n(rst_n),
      .bus(ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act,
                        input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)",
                  name, act, req, $time);
      end
   endtask

   task automatic check_acc(input string name, input longint want);
      logic [AW-1:0] w;
      w = AW'(want);
      check(name, ifc.rsp_acc, w);
   endtask

   for (genvar g = 0; g < N_REQ; g++) begin : rq
      beat_t q[$];
      logic r = 1'b0;
      logic [DW-1:0] x = '0;
      logic [CW-1:0] c = '0;
      logic l = 1'b0;
      bit took;
      bit armed = 1'b0;
      int wait_n = 0;

      assign ifc.req[g] = r;
      assign ifc.req_x[g] = x;
      assign ifc.req_c[g] = c;
      assign ifc.req_last[g] = l;

      always begin
         @(negedge clk);
         took = r && ifc.gnt[g];
         @(posedge clk);
         #1;
         if (took && q.size() > 0) begin
            void'(q.pop_front());
            armed = 1'b0;
         end
         if (q.size() == 0) begin
            r = 1'b0;
            armed = 1'b0;
         end else begin
            if (!armed) begin
               armed = 1'b1;
               wait_n = q[0].gap;
            end
            if (wait_n > 0) begin
               r = 1'b0;
               wait_n--;
            end else begin
               r = 1'b1;
               x = DW'(q[0].x);
               c = CW'(q[0].c);
               l = q[0].last;
            end
         end
      end
   end

   // Reference: burst-level round robin plus plain-arithmetic sums.
   int own = -1;
   int rr = 0;
   int nb = 0;
   bit err_m = 1'b0;
   logic [AW-1:0] acc_m = '0;

   always @(negedge clk) begin : model
      logic [N_REQ-1:0] eg;
      int id;
      longint p;
      eg = '0;
      if (!rst_n) begin
         own = -1;
         rr = 0;
         nb = 0;
         err_m = 1'b0;
         exp_q.delete();
         check("gnt_in_reset", ifc.gnt, 0);
      end else begin
         id = -1;
         if (own >= 0) begin
            if (ifc.req[own]) id = own;
         end else begin
            for (int k = 1; k <= N_REQ; k++)
               if (id < 0 && ifc.req[(rr + k) % N_REQ])
                  id = (rr + k) % N_REQ;
         end
         if (id >= 0) eg[id] = 1'b1;
         check("gnt", ifc.gnt, eg);
         check("err_overrun", ifc.err_overrun, err_m);
         if (id >= 0) begin
            p = longint'($signed(ifc.req_x[id])) *
                longint'($signed(ifc.req_c[id]));
            if (own < 0) begin
               acc_m = AW'(p);
               nb = 1;
            end else begin
               acc_m = acc_m + AW'(p);
               nb++;
            end
            if (ifc.req_last[id] || nb == MAX_BEATS) begin
               if (!ifc.req_last[id]) err_m = 1'b1;
               exp_q.push_back('{id, acc_m, cyc + 2});
               rr = id;
               own = -1;
            end else begin
               own = id;
            end
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst_n) begin
         check("rsp_valid_in_reset", ifc.rsp_valid, 0);
      end else if (ifc.rsp_valid != '0) begin
         for (int k = 0; k < N_REQ; k++)
            if (ifc.rsp_valid[k]) seen.push_back(k);
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", ifc.rsp_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", ifc.rsp_valid, 1 << e.id);
            check("rsp_acc", ifc.rsp_acc, e.acc);
            check("rsp_latency", cyc, e.due);
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e = exp_q.pop_front();
         check("rsp_missing", ifc.rsp_valid, 1 << e.id);
      end
   end

   task automatic push(input int g, input int x, input int c,
                       input bit last, input int gap);
      beat_t b;
      b = '{x, c, last, gap};
      case (g)
         0: rq[0].q.push_back(b);
         1: rq[1].q.push_back(b);
         default: rq[2].q.push_back(b);
      endcase
   endtask

   function automatic int qsize(input int g);
      case (g)
         0: return rq[0].q.size();
         1: return rq[1].q.size();
         default: return rq[2].q.size();
      endcase
   endfunction

   task automatic wait_size(input string name, input int g, input int n);
      for (int i = 0; i < 500; i++) begin
         @(posedge clk);
         #2;
         if (qsize(g) <= n) return;
      end
      checks++;
      errors++;
      $display("FAIL %s_timeout: queue %0d still %0d, want <= %0d",
               name, g, qsize(g), n);
   endtask

   task automatic wait_idle(input string name);
      int quiet;
      quiet = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         if (qsize(0) == 0 && qsize(1) == 0 && qsize(2) == 0 &&
             exp_q.size() == 0)
            quiet++;
         else
            quiet = 0;
         if (quiet >= 3) return;
      end
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d responses outstanding, want 0",
               name, exp_q.size());
   endtask

   task automatic do_reset(input string name);
      rst_n = 1'b0;
      #1;
      check({name, "_gnt"}, ifc.gnt, 0);
      check({name, "_rsp_valid"}, ifc.rsp_valid, 0);
      check({name, "_err"}, ifc.err_overrun, 0);
      check({name, "_acc"}, ifc.rsp_acc, 0);
   endtask

   initial begin
      int rr_exp[6];
      int n;
      rr_exp = '{1, 2, 0, 1, 2, 0};

      #1;
      do_reset("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      push(0, 100, -3, 1'b1, 0);
      wait_idle("single");
      check_acc("single_acc", -300);

      for (int i = 1; i <= 4; i++) push(1, i, 1000, i == 4, 0);
      push(2, 7, -9, 1'b1, 0);
      wait_idle("burst4");
      check_acc("burst4_tail_acc", -63);

      @(posedge clk);
      #1;
      do_reset("rr_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      seen.delete();
      for (int b = 0; b < 2; b++)
         for (int g = 0; g < N_REQ; g++) begin
            push(g, g * 10 + b + 1, 3, 1'b0, 0);
            push(g, -(g + 2), 5 + b, 1'b1, 0);
         end
      wait_idle("rr");
      check("rr_count", seen.size(), 6);
      n = (seen.size() < 6) ? seen.size() : 6;
      for (int i = 0; i < n; i++) check("rr_order", seen[i], rr_exp[i]);

      push(0, 32767, 131071, 1'b0, 0);
      push(0, 32767, 131071, 1'b1, 3);
      wait_size("stall", 0, 1);
      push(1, -32768, -131072, 1'b1, 0);
      wait_idle("stall");
      check_acc("b2b_acc", 64'sd4294967296);

      for (int i = 0; i < MAX_BEATS; i++) push(2, 1, 1, 1'b0, 0);
      push(2, 5, 1, 1'b1, 0);
      wait_idle("overrun");
      check("err_sticky", ifc.err_overrun, 1);
      check_acc("overrun_tail_acc", 5);

      for (int i = 1; i <= 4; i++) push(1, 50 * i, 7, i == 4, 0);
      wait_size("midrst", 1, 2);
      do_reset("mid_rst");
      for (int g = 0; g < N_REQ; g++)
         case (g)
            0: rq[0].q.delete();
            1: rq[1].q.delete();
            default: rq[2].q.delete();
         endcase
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      push(0, 3, 5, 1'b0, 0);
      push(0, -7, 11, 1'b0, 0);
      push(0, 100, -2, 1'b1, 0);
      wait_idle("post_rst");
      check_acc("post_rst_acc", -262);

      for (int b = 0; b < 8; b++)
         for (int g = 0; g < N_REQ; g++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++)
               push(g, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 262143)) - 131072,
                    i == n - 1,
                    ($urandom_range(0, 9) < 3) ? $urandom_range(1, 2) : 0);
         end
      wait_idle("random");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
